// File: rtl/rob_cpl_arb_pkg.sv
// Shared types and constants for the ROB completion-port arbiter.
// Build option ROB_CPL_ARB_BYPASS_EN is consumed by rob_cpl_arb.sv.
package rob_cpl_arb_pkg;

   localparam int NUM_COMPLETES     = 2;
   localparam int RB_CPL_ARB_QDEPTH = 2;
   localparam int ROBID_W           = 7;
   localparam int CPL_ARB_IDX_W     = 4;

   typedef struct packed {
      logic               valid;
      logic [ROBID_W-1:0] robid;
      logic               exc;
      logic [3:0]         exc_code;
   } t_rob_complete_pkt;

   typedef struct packed {
      logic               valid;
      logic [ROBID_W-1:0] robid;
   } t_nuke_pkt;

   typedef struct packed {
      logic                     valid;
      logic [CPL_ARB_IDX_W-1:0] idx;
   } t_rob_cpl_arb_gnt;

endpackage

// File: rtl/rob_cpl_queue.sv
// Per-source completion FIFO of DEPTH packets; pointers wrap modulo DEPTH so
// non-power-of-2 depths work. Flush empties the queue at the next edge.
module rob_cpl_queue
   import rob_cpl_arb_pkg::*;
#(
   parameter int DEPTH = RB_CPL_ARB_QDEPTH
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  t_rob_complete_pkt push_pkt,
   input  logic              pop,
   input  logic              flush,
   output t_rob_complete_pkt head_pkt,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   t_rob_complete_pkt r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_cnt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({push, pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset; only the pointers and count qualify its contents.
   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[r_wr_ptr] <= push_pkt;
   end

   assign head_pkt = r_mem[r_rd_ptr];
   assign empty    = (r_cnt == '0);
   assign full     = (r_cnt == CNT_W'(DEPTH));

   a_no_pop_empty:  assert property (@(posedge clk) disable iff (reset) !(pop && empty));
   a_no_push_full:  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/rob_cpl_arb.sv
// Completion-port arbiter: per-source queues, round-robin multi-grant onto
// NUM_PORTS registered ROB completion ports, flushed by nuke. Optional
// same-cycle bypass of empty queues with `define ROB_CPL_ARB_BYPASS_EN.
module rob_cpl_arb
   import rob_cpl_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_PORTS = NUM_COMPLETES,
   parameter int QDEPTH    = RB_CPL_ARB_QDEPTH
)
(
   input  logic              clk,
   input  logic              reset,
   input  t_rob_complete_pkt req_pkt_rb0 [NUM_REQ],
   output logic [NUM_REQ-1:0] req_ready_rb0,
   input  t_nuke_pkt         nuke_rb1,
   output t_rob_complete_pkt cpl_pkt_rb1 [NUM_PORTS]
);

   localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] w_empty;
   logic [NUM_REQ-1:0] w_full;
   logic [NUM_REQ-1:0] w_accept;
   logic [NUM_REQ-1:0] w_push;
   logic [NUM_REQ-1:0] w_pop;
   logic [NUM_REQ-1:0] w_cand;
   logic [NUM_REQ-1:0] w_won;
   t_rob_complete_pkt  w_head     [NUM_REQ];
   t_rob_complete_pkt  w_cand_pkt [NUM_REQ];
   t_rob_cpl_arb_gnt   w_gnt      [NUM_PORTS];
   t_rob_complete_pkt  w_cpl_next [NUM_PORTS];
   logic [RR_W-1:0]    w_last;
   logic [RR_W-1:0]    w_rr_next;
   logic               w_unused;

   logic [RR_W-1:0]    r_rr_ptr;
   t_rob_complete_pkt  r_cpl_pkt [NUM_PORTS];

   assign w_unused = ^nuke_rb1.robid;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
         assign req_ready_rb0[gi] = ~reset & ~w_full[gi];
         assign w_accept[gi]      = req_pkt_rb0[gi].valid & req_ready_rb0[gi] & ~nuke_rb1.valid;

`ifdef ROB_CPL_ARB_BYPASS_EN
         // An empty queue offers the incoming packet directly; it is only
         // written to the queue if it loses arbitration.
         assign w_cand[gi]     = ~w_empty[gi] | req_pkt_rb0[gi].valid;
         assign w_cand_pkt[gi] = w_empty[gi] ? req_pkt_rb0[gi] : w_head[gi];
         assign w_push[gi]     = w_accept[gi] & ~(w_empty[gi] & w_won[gi]);
         assign w_pop[gi]      = w_won[gi] & ~w_empty[gi] & ~nuke_rb1.valid;
`else
         assign w_cand[gi]     = ~w_empty[gi];
         assign w_cand_pkt[gi] = w_head[gi];
         assign w_push[gi]     = w_accept[gi];
         assign w_pop[gi]      = w_won[gi] & ~nuke_rb1.valid;
`endif

         rob_cpl_queue #(
            .DEPTH (QDEPTH)
         ) u_queue (
            .clk      (clk),
            .reset    (reset),
            .push     (w_push[gi]),
            .push_pkt (req_pkt_rb0[gi]),
            .pop      (w_pop[gi]),
            .flush    (nuke_rb1.valid),
            .head_pkt (w_head[gi]),
            .empty    (w_empty[gi]),
            .full     (w_full[gi])
         );

         a_vassert_ready: assert property (@(posedge clk) disable iff (reset)
            !(req_pkt_rb0[gi].valid && !req_ready_rb0[gi]));
      end
   endgenerate

   // Find-first from rr_ptr, repeated once per port, skipping sources already won.
   always_comb begin
      logic [RR_W-1:0] v_idx;
      v_idx  = '0;
      w_won  = '0;
      w_last = r_rr_ptr;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_gnt[p] = '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = RR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_gnt[p].valid && w_cand[v_idx] && !w_won[v_idx]) begin
               w_gnt[p].valid = 1'b1;
               w_gnt[p].idx   = CPL_ARB_IDX_W'(v_idx);
               w_won[v_idx]   = 1'b1;
               w_last         = v_idx;
            end
         end
      end
   end

   assign w_rr_next = (w_last == RR_W'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_cpl_next[p] = '0;
         if (w_gnt[p].valid && !nuke_rb1.valid) begin
            w_cpl_next[p]       = w_cand_pkt[RR_W'(w_gnt[p].idx)];
            w_cpl_next[p].valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr <= '0;
         for (int p = 0; p < NUM_PORTS; p++) r_cpl_pkt[p] <= '0;
      end else begin
         if (w_gnt[0].valid && !nuke_rb1.valid) r_rr_ptr <= w_rr_next;
         for (int p = 0; p < NUM_PORTS; p++) r_cpl_pkt[p] <= w_cpl_next[p];
      end
   end

   assign cpl_pkt_rb1 = r_cpl_pkt;

endmodule
